// File: rtl/serial_parity_checker.sv
// Serial parity checker: accumulates WIDTH data bits (LSB first), then compares
// the received parity bit against the latched mode and keeps a saturating error count.
module serial_parity_checker #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       parity_type,
  input  logic             start,
  input  logic             abort,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             clr_count,
  output logic             busy,
  output logic             parity_bit,
  output logic             done,
  output logic             parity_err,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned CNT_BW = $clog2(WIDTH + 1);
  localparam logic [CNT_BW-1:0] LAST_BIT = CNT_BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PAR
  } state_t;

  typedef enum logic [2:0] {
    M_NONE,
    M_ODD,
    M_EVEN,
    M_MARK,
    M_SPACE
  } mode_t;

  state_t            state_q, state_d;
  mode_t             mode_q, mode_d, mode_in;
  logic              acc_q, acc_d;
  logic [CNT_BW-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              perr_q, perr_d;
  logic [CNT_W-1:0]  errcnt_q, errcnt_d;
  logic              err_inc;
  logic              exp_par;

  // Reserved encodings 101..111 fall back to no parity.
  always_comb begin
    case (parity_type)
      3'b001:  mode_in = M_ODD;
      3'b010:  mode_in = M_EVEN;
      3'b011:  mode_in = M_MARK;
      3'b100:  mode_in = M_SPACE;
      default: mode_in = M_NONE;
    endcase
  end

  always_comb begin
    case (mode_q)
      M_ODD:   exp_par = ~acc_q;
      M_EVEN:  exp_par = acc_q;
      M_MARK:  exp_par = 1'b1;
      default: exp_par = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    perr_d  = perr_q;
    err_inc = 1'b0;
    // abort overrides every transition, including a start or final bit in the same cycle
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_DATA;
            mode_d  = mode_in;
            acc_d   = 1'b0;
            cnt_d   = '0;
            perr_d  = 1'b0;
          end
        end
        S_DATA: begin
          if (bit_valid) begin
            acc_d = acc_q ^ bit_in;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
              if (mode_q == M_NONE) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                perr_d  = 1'b0;
              end else begin
                state_d = S_PAR;
              end
            end
          end
        end
        S_PAR: begin
          if (bit_valid) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            perr_d  = (bit_in != exp_par);
            err_inc = (bit_in != exp_par);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    errcnt_d = errcnt_q;
    if (clr_count) begin
      errcnt_d = '0;
    end else if (err_inc && (errcnt_q != '1)) begin
      errcnt_d = errcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mode_q   <= M_NONE;
      acc_q    <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      perr_q   <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      perr_q   <= perr_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign parity_bit = (state_q == S_PAR) & exp_par;
  assign done       = done_q;
  assign parity_err = perr_q;
  assign err_count  = errcnt_q;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Scoreboard bench: stimulus pushes the expected frame result, a monitor pops it on done.
module tb_serial_parity_checker;

  localparam int WIDTH = 8;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       parity_type;
  logic             start, abort, bit_valid, bit_in, clr_count;
  logic             busy, parity_bit, done, parity_err;
  logic [CNT_W-1:0] err_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic             perr;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   cnt_m  = 0;
  bit   perr_m = 1'b0;

  serial_parity_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .parity_type(parity_type), .start(start), .abort(abort),
    .bit_valid(bit_valid), .bit_in(bit_in), .clr_count(clr_count), .busy(busy),
    .parity_bit(parity_bit), .done(done), .parity_err(parity_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expected frame.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("frame_parity_err", int'(parity_err), int'(e.perr));
        chk("frame_err_count", int'(err_count), int'(e.cnt));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_none(input int m);
    return !(m inside {1, 2, 3, 4});
  endfunction

  // Reference parity from the number of ones in the data word.
  function automatic bit ref_parity(input int m, input logic [7:0] d);
    int ones;
    ones = $countones(d);
    case (m)
      1:       return (ones % 2) == 0;
      2:       return (ones % 2) == 1;
      3:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic idle_gap(input int gaps);
    int n;
    n = $urandom_range(0, gaps);
    repeat (n) begin
      bit_valid   = 1'b0;
      bit_in      = 1'($urandom);
      start       = 1'($urandom);
      parity_type = 3'($urandom);
      step();
    end
    start = 1'b0;
  endtask

  // abort_at: 0..7 aborts before that data bit, 8 aborts in the parity phase, -1 none.
  task automatic send_frame(input int m, input logic [7:0] d, input logic p,
                            input int gaps, input bit clr, input int abort_at);
    bit none_m, err;
    exp_t e;
    none_m = is_none(m);
    start = 1'b1;
    parity_type = 3'(m);
    step();
    start = 1'b0;
    perr_m = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      idle_gap(gaps);
      if (abort_at == i) begin
        abort = 1'b1;
        bit_valid = 1'b1;
        bit_in = d[i];
        step();
        abort = 1'b0;
        bit_valid = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_parity_err", int'(parity_err), int'(perr_m));
        return;
      end
      bit_valid = 1'b1;
      bit_in = d[i];
      if (i == WIDTH - 1 && none_m) begin
        clr_count = clr;
        if (clr) cnt_m = 0;
        e.perr = 1'b0;
        e.cnt  = CNT_W'(cnt_m);
        exp_q.push_back(e);
      end
      step();
      bit_valid = 1'b0;
      clr_count = 1'b0;
    end
    if (none_m) begin
      chk("none_done_on_last_bit", int'(done), 1);
      chk("none_busy_after", int'(busy), 0);
      return;
    end
    chk("par_busy", int'(busy), 1);
    chk("par_parity_bit", int'(parity_bit), int'(ref_parity(m, d)));
    idle_gap(gaps);
    if (abort_at == 8) begin
      abort = 1'b1;
      bit_valid = 1'b1;
      bit_in = p;
      step();
      abort = 1'b0;
      bit_valid = 1'b0;
      chk("abort_par_busy", int'(busy), 0);
      chk("abort_par_parity_err", int'(parity_err), int'(perr_m));
      return;
    end
    err = (p != ref_parity(m, d));
    perr_m = err;
    if (clr) cnt_m = 0;
    else if (err && cnt_m < CMAX) cnt_m++;
    e.perr = err;
    e.cnt  = CNT_W'(cnt_m);
    exp_q.push_back(e);
    bit_valid = 1'b1;
    bit_in = p;
    clr_count = clr;
    step();
    bit_valid = 1'b0;
    clr_count = 1'b0;
    chk("frame_end_busy", int'(busy), 0);
    chk("frame_end_parity_bit", int'(parity_bit), 0);
  endtask

  initial begin
    int seq[5] = '{1, 2, 3, 3, 3};
    rst = 1'b1;
    parity_type = '0;
    start = 1'b0; abort = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; clr_count = 1'b0;
    repeat (3) step();
    chk("rst_busy", int'(busy), 0);
    chk("rst_parity_bit", int'(parity_bit), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_parity_err", int'(parity_err), 0);
    chk("rst_err_count", int'(err_count), 0);
    rst = 1'b0;
    step();

    send_frame(2, 8'hA5, 1'b0, 0, 1'b0, -1);
    chk("even_a5_err", int'(parity_err), 0);
    send_frame(1, 8'hA5, 1'b0, 0, 1'b0, -1);
    chk("odd_a5_err", int'(parity_err), 1);
    chk("odd_a5_count", int'(err_count), 1);
    send_frame(3, 8'h00, 1'b0, 0, 1'b0, -1);
    chk("mark_err", int'(parity_err), 1);
    send_frame(4, 8'h00, 1'b0, 0, 1'b0, -1);
    chk("space_err", int'(parity_err), 0);
    send_frame(0, 8'hFF, 1'b0, 0, 1'b0, -1);
    chk("none_err", int'(parity_err), 0);
    step();
    chk("none_done_one_cycle", int'(done), 0);

    clr_count = 1'b1;
    cnt_m = 0;
    step();
    clr_count = 1'b0;
    chk("clr_count_alone", int'(err_count), 0);
    for (int k = 0; k < 5; k++) begin
      send_frame(1, 8'hA5, 1'b0, 1, 1'b0, -1);
      chk("sat_seq", int'(err_count), seq[k]);
    end
    send_frame(1, 8'hA5, 1'b0, 1, 1'b1, -1);
    chk("clr_beats_inc", int'(err_count), 0);

    send_frame(2, 8'h3C, 1'b1, 0, 1'b0, 4);
    step();
    chk("abort_idle_done", int'(done), 0);
    start = 1'b1; parity_type = 3'd1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1; bit_in = 1'b1;
      step();
    end
    bit_valid = 1'b0;
    rst = 1'b1;
    #1;
    cnt_m = 0; perr_m = 1'b0;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_parity_bit", int'(parity_bit), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_err_count", int'(err_count), 0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_busy", int'(busy), 0);

    start = 1'b1; abort = 1'b1; parity_type = 3'd2;
    step();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", int'(busy), 0);

    for (int f = 0; f < 150; f++) begin
      int m, ab;
      m  = $urandom_range(0, 7);
      ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 8) : -1;
      send_frame(m, 8'($urandom), 1'($urandom), 2, ($urandom_range(0, 7) == 0), ab);
    end

    repeat (3) step();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
